// File: rtl/bist_tpg.sv
// bist_tpg: logic-BIST stimulus generator. A 16-bit Fibonacci LFSR fills the CUT scan chain and
// primary inputs under a shift/capture/unload sequencer. Reseed ports exist only with BIST_TPG_RESEED_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start, outputs quiet
// SHIFT   | scan chain loads lfsr[15] each cycle, CHAIN_LEN cycles
// CAPTURE | one functional cycle, PIs driven from the lfsr
// UNLOAD  | final chain flush with zeros so the last response is compacted
// DONE    | sequence complete, done held until start or reset

module bist_tpg #(
   parameter int          CHAIN_LEN    = 32,
   parameter int          NUM_PATTERNS = 256,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
`ifdef BIST_TPG_RESEED_EN
   input  logic        reseed,
   input  logic [15:0] reseed_val,
`endif
   output logic        scan_in,
   output logic        scan_en,
   output logic        cut_fz_L,
   output logic        cut_lclk,
   output logic [4:0]  cut_read_a,
   output logic        misr_en,
   output logic        busy,
   output logic        done
);

   localparam int          SW         = $clog2(CHAIN_LEN + 1);
   localparam int          PW         = $clog2(NUM_PATTERNS + 1);
   localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
   localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PATTERNS - 1);
   localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      CAPTURE,
      UNLOAD,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [15:0]   lfsr;
   logic [15:0]   lfsr_nxt;
   logic [SW-1:0] shift_cnt;
   logic [SW-1:0] shift_cnt_nxt;
   logic [PW-1:0] pat_cnt;
   logic [PW-1:0] pat_cnt_nxt;
   logic [15:0]   seed_pick;

   // An all-zero register would never leave zero, so it is forced back to 1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      if (v == 16'h0000)
         return 16'h0001;
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

`ifdef BIST_TPG_RESEED_EN
   logic [15:0] seed_reg;
   logic [15:0] reseed_fix;
   assign reseed_fix = (reseed_val == 16'h0000) ? 16'h0001 : reseed_val;
   assign seed_pick  = reseed ? reseed_fix : seed_reg;
`else
   assign seed_pick  = SEED_EFF;
`endif

   always_comb begin
      state_nxt     = state;
      lfsr_nxt      = lfsr;
      shift_cnt_nxt = shift_cnt;
      pat_cnt_nxt   = pat_cnt;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt     = SHIFT;
               lfsr_nxt      = seed_pick;
               shift_cnt_nxt = SHIFT_LAST;
               pat_cnt_nxt   = '0;
            end
`ifdef BIST_TPG_RESEED_EN
            else if (reseed) begin
               lfsr_nxt = reseed_fix;
            end
`endif
         end
         SHIFT: begin
            lfsr_nxt = lfsr_step(lfsr);
            if (shift_cnt == '0)
               state_nxt = CAPTURE;
            else
               shift_cnt_nxt = shift_cnt - SW'(1);
         end
         CAPTURE: begin
            lfsr_nxt      = lfsr_step(lfsr);
            pat_cnt_nxt   = pat_cnt + PW'(1);
            shift_cnt_nxt = SHIFT_LAST;
            state_nxt     = (pat_cnt == PAT_LAST) ? UNLOAD : SHIFT;
         end
         UNLOAD: begin
            if (shift_cnt == '0)
               state_nxt = DONE;
            else
               shift_cnt_nxt = shift_cnt - SW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         lfsr       <= SEED_EFF;
         shift_cnt  <= '0;
         pat_cnt    <= '0;
         scan_in    <= 1'b0;
         scan_en    <= 1'b0;
         cut_fz_L   <= 1'b0;
         cut_lclk   <= 1'b0;
         cut_read_a <= 5'd0;
         misr_en    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef BIST_TPG_RESEED_EN
         seed_reg   <= SEED_EFF;
`endif
      end else begin
         state     <= state_nxt;
         lfsr      <= lfsr_nxt;
         shift_cnt <= shift_cnt_nxt;
         pat_cnt   <= pat_cnt_nxt;
         scan_en   <= (state_nxt == SHIFT) || (state_nxt == UNLOAD);
         scan_in   <= (state_nxt == SHIFT) && lfsr_nxt[15];
         // First chain unload carries reset garbage, so compaction starts with pattern 2.
         misr_en   <= ((state_nxt == SHIFT) && (pat_cnt_nxt != '0)) || (state_nxt == UNLOAD);
         busy      <= (state_nxt != IDLE) && (state_nxt != DONE);
         done      <= (state_nxt == DONE);
         if (state_nxt == CAPTURE) begin
            cut_fz_L   <= lfsr_nxt[0];
            cut_lclk   <= lfsr_nxt[1];
            cut_read_a <= lfsr_nxt[6:2];
         end
`ifdef BIST_TPG_RESEED_EN
         if (((state == IDLE) || (state == DONE)) && reseed)
            seed_reg <= reseed_fix;
`endif
      end
   end

endmodule

// File: tb/tb_bist_tpg.sv
// tb_bist_tpg: scoreboard bench for bist_tpg; a behavioural pattern model queues expected output
// vectors per cycle. Reseed scenario runs only when BIST_TPG_RESEED_EN is defined.

module tb_bist_tpg;

   localparam int CL   = 4;
   localparam int NP   = 3;
   localparam int NP_Z = 200;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        start_z;
   logic        scan_in, scan_en, cut_fz_L, cut_lclk, misr_en, busy, done;
   logic [4:0]  cut_read_a;
   logic        z_scan_in, z_scan_en, z_fz_L, z_lclk, z_misr_en, z_busy, z_done;
   logic [4:0]  z_read_a;
`ifdef BIST_TPG_RESEED_EN
   logic        reseed;
   logic [15:0] reseed_val;
`endif

   always #5 clock = ~clock;

   bist_tpg #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .SEED(16'h0001)) dut (
      .clock(clock), .reset(reset), .start(start),
`ifdef BIST_TPG_RESEED_EN
      .reseed(reseed), .reseed_val(reseed_val),
`endif
      .scan_in(scan_in), .scan_en(scan_en), .cut_fz_L(cut_fz_L), .cut_lclk(cut_lclk),
      .cut_read_a(cut_read_a), .misr_en(misr_en), .busy(busy), .done(done)
   );

   bist_tpg #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP_Z), .SEED(16'h0000)) dut_z (
      .clock(clock), .reset(reset), .start(start_z),
`ifdef BIST_TPG_RESEED_EN
      .reseed(1'b0), .reseed_val(16'h0000),
`endif
      .scan_in(z_scan_in), .scan_en(z_scan_en), .cut_fz_L(z_fz_L), .cut_lclk(z_lclk),
      .cut_read_a(z_read_a), .misr_en(z_misr_en), .busy(z_busy), .done(z_done)
   );

   typedef struct packed {
      logic       scan_in;
      logic       scan_en;
      logic       fz;
      logic       lclk;
      logic [4:0] read_a;
      logic       misr_en;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       m_fz = 1'b0;
   logic       m_lclk = 1'b0;
   logic [4:0] m_ra = 5'd0;

   function automatic logic [15:0] step(input logic [15:0] v);
      if (v == 16'h0000) return 16'h0001;
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic vec_t mk(input logic si, input logic se, input logic mi,
                               input logic bz, input logic dn);
      vec_t v;
      v.scan_in = si; v.scan_en = se; v.fz = m_fz; v.lclk = m_lclk; v.read_a = m_ra;
      v.misr_en = mi; v.busy = bz; v.done = dn;
      return v;
   endfunction

   // Expected per-cycle outputs from the first SHIFT cycle through DONE entry.
   task automatic push_run(input logic [15:0] seed, input int cl, input int np);
      logic [15:0] lf;
      lf = (seed == 16'h0000) ? 16'h0001 : seed;
      for (int p = 0; p < np; p++) begin
         for (int s = 0; s < cl; s++) begin
            exp_q.push_back(mk(lf[15], 1'b1, p != 0, 1'b1, 1'b0));
            lf = step(lf);
         end
         m_fz = lf[0]; m_lclk = lf[1]; m_ra = lf[6:2];
         exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
         lf = step(lf);
      end
      for (int s = 0; s < cl; s++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
   endtask

   task automatic test_reset();
      vec_t o;
      reset = 1'b1; start = 1'b0; start_z = 1'b0;
`ifdef BIST_TPG_RESEED_EN
      reseed = 1'b0; reseed_val = 16'h0000;
`endif
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         o = {scan_in, scan_en, cut_fz_L, cut_lclk, cut_read_a, misr_en, busy, done};
         checks++;
         if (o !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: got %h expected 000", i, o);
         end
      end
   endtask

   task automatic test_first_run();
      vec_t o, e;
      int   cyc = 0, done_cyc = -1, misr_cnt = 0;
      push_run(16'h0001, CL, NP);
      start = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         start = 1'b0;
         cyc++;
         e = exp_q.pop_front();
         o = {scan_in, scan_en, cut_fz_L, cut_lclk, cut_read_a, misr_en, busy, done};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL first_run cyc %0d: got %h expected %h", cyc, o, e);
         end
         if (cyc <= 4) begin
            checks++;
            if (scan_in !== 1'b0 || scan_en !== 1'b1 || misr_en !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL first_shift cyc %0d: got si=%b se=%b me=%b bz=%b expected 0 1 0 1",
                        cyc, scan_in, scan_en, misr_en, busy);
            end
         end
         if (cyc == 5) begin
            checks++;
            if (scan_en !== 1'b0 || cut_read_a !== 5'd4 || cut_fz_L !== 1'b0 || cut_lclk !== 1'b0) begin
               errors++;
               $display("FAIL first_capture: got se=%b ra=%0d fz=%b lc=%b expected 0 4 0 0",
                        scan_en, cut_read_a, cut_fz_L, cut_lclk);
            end
         end
         if (misr_en === 1'b1) misr_cnt++;
         if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      end
      checks++;
      if (done_cyc != 20) begin
         errors++;
         $display("FAIL done_cycle: got %0d expected 20", done_cyc);
      end
      checks++;
      if (misr_cnt != 12) begin
         errors++;
         $display("FAIL misr_cycles: got %0d expected 12", misr_cnt);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL done_hold: got done=%b busy=%b expected 1 0", done, busy);
      end
   endtask

   task automatic test_back_to_back();
      vec_t o, e;
      int   cyc = 0;
      push_run(16'h0001, CL, NP);
      start = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         start = 1'b0;
         cyc++;
         e = exp_q.pop_front();
         o = {scan_in, scan_en, cut_fz_L, cut_lclk, cut_read_a, misr_en, busy, done};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL restart_from_done cyc %0d: got %h expected %h", cyc, o, e);
         end
      end
   endtask

   task automatic test_start_ignored_and_reset();
      vec_t o, e;
      int   cyc = 0;
      push_run(16'h0001, CL, NP);
      start = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         start = (cyc == 1);
         cyc++;
         e = exp_q.pop_front();
         o = {scan_in, scan_en, cut_fz_L, cut_lclk, cut_read_a, misr_en, busy, done};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL start_ignored cyc %0d: got %h expected %h", cyc, o, e);
         end
         if (cyc == 17) begin
            reset = 1'b1;
            exp_q.delete();
         end
      end
      @(negedge clock);
      reset = 1'b0;
      m_fz = 1'b0; m_lclk = 1'b0; m_ra = 5'd0;
      o = {scan_in, scan_en, cut_fz_L, cut_lclk, cut_read_a, misr_en, busy, done};
      checks++;
      if (o !== '0) begin
         errors++;
         $display("FAIL reset_in_unload: got %h expected 000", o);
      end
      cyc = 0;
      push_run(16'h0001, CL, NP);
      start = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         start = 1'b0;
         cyc++;
         e = exp_q.pop_front();
         o = {scan_in, scan_en, cut_fz_L, cut_lclk, cut_read_a, misr_en, busy, done};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rerun_after_reset cyc %0d: got %h expected %h", cyc, o, e);
         end
      end
   endtask

   task automatic test_lockup_guard();
      vec_t       o, e;
      int         cyc = 0;
      logic       s_fz, s_lclk;
      logic [4:0] s_ra;
      s_fz = m_fz; s_lclk = m_lclk; s_ra = m_ra;
      m_fz = 1'b0; m_lclk = 1'b0; m_ra = 5'd0;
      checks++;
      if (dut_z.lfsr !== 16'h0001) begin
         errors++;
         $display("FAIL zero_seed_load: got %h expected 0001", dut_z.lfsr);
      end
      push_run(16'h0000, CL, NP_Z);
      start_z = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clock);
         start_z = 1'b0;
         cyc++;
         e = exp_q.pop_front();
         o = {z_scan_in, z_scan_en, z_fz_L, z_lclk, z_read_a, z_misr_en, z_busy, z_done};
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL zero_seed_run cyc %0d: got %h expected %h", cyc, o, e);
         end
         checks++;
         if (dut_z.lfsr === 16'h0000) begin
            errors++;
            $display("FAIL lfsr_nonzero cyc %0d: got 0000 expected nonzero", cyc);
         end
      end
      m_fz = s_fz; m_lclk = s_lclk; m_ra = s_ra;
   endtask

`ifdef BIST_TPG_RESEED_EN
   task automatic test_reseed();
      vec_t o, e;
      int   cyc;
      reseed = 1'b1; reseed_val = 16'h8000;
      @(negedge clock);
      reseed = 1'b0;
      for (int r = 0; r < 2; r++) begin
         cyc = 0;
         push_run(16'h8000, CL, NP);
         start = 1'b1;
         while (exp_q.size() > 0) begin
            @(negedge clock);
            start = 1'b0;
            reseed = (cyc == 2);
            reseed_val = 16'h1234;
            cyc++;
            e = exp_q.pop_front();
            o = {scan_in, scan_en, cut_fz_L, cut_lclk, cut_read_a, misr_en, busy, done};
            checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL reseed_run%0d cyc %0d: got %h expected %h", r, cyc, o, e);
            end
            if (cyc == 1) begin
               checks++;
               if (scan_in !== 1'b1) begin
                  errors++;
                  $display("FAIL reseed_first_bit: got %b expected 1", scan_in);
               end
            end
         end
         reseed = 1'b0;
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_run();
      test_back_to_back();
      test_start_ignored_and_reset();
      test_lockup_guard();
`ifdef BIST_TPG_RESEED_EN
      test_reseed();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
